// File: rtl/alu_pkg.sv
// Shared opcode encodings and flag bit positions for the pipelined ALU.
package alu_pkg;

  localparam logic [2:0] OP_MOV = 3'b000;
  localparam logic [2:0] OP_NOT = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_AND = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  localparam int FLG_C = 0;
  localparam int FLG_V = 1;
  localparam int FLG_Z = 2;
  localparam int FLG_N = 3;

endpackage

// File: rtl/alu_pipe_if.sv
// Operand/result handshake bundle between register-file read port, ALU and write-back.
interface alu_pipe_if #(
  parameter int N  = 32,
  parameter int CW = 16
);
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    ALUOp;
  logic          c_in;
  logic [N-1:0]  R2;
  logic [N-1:0]  R3;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  R1;
  logic          c_out;
  logic          ovf;
  logic          zero;
  logic          neg;
  logic [CW-1:0] op_count;

  modport slave (
    input  in_valid, ALUOp, c_in, R2, R3, out_ready,
    output in_ready, out_valid, R1, c_out, ovf, zero, neg, op_count
  );

  modport master (
    output in_valid, ALUOp, c_in, R2, R3, out_ready,
    input  in_ready, out_valid, R1, c_out, ovf, zero, neg, op_count
  );
endinterface

// File: rtl/alu_core.sv
// Combinational ALU datapath: result plus carry/no-borrow and signed overflow.
// Optional ALU_PIPE_SAT_EN clamps overflowing ADD/SUB results to the signed range.
module alu_core
  import alu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [2:0]   i_op,
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_cin,
  output logic [N-1:0] o_result,
  output logic         o_c_out,
  output logic         o_ovf
);

  logic [N-1:0] w_b_eff;
  logic         w_cin_eff;
  logic [N:0]   w_sum;
  logic         w_arith_ovf;

  // SUB shares the adder as A + ~B + 1
  always_comb begin
    w_b_eff     = (i_op == OP_SUB) ? ~i_b : i_b;
    w_cin_eff   = (i_op == OP_SUB) ? 1'b1 : i_cin;
    w_sum       = {1'b0, i_a} + {1'b0, w_b_eff} + {{N{1'b0}}, w_cin_eff};
    w_arith_ovf = (i_a[N-1] == w_b_eff[N-1]) && (w_sum[N-1] != i_a[N-1]);
  end

  always_comb begin
    o_result = '0;
    o_c_out  = 1'b0;
    o_ovf    = 1'b0;
    case (i_op)
      OP_MOV: o_result = i_a;
      OP_NOT: o_result = ~i_a;
      OP_ADD, OP_SUB: begin
        o_result = w_sum[N-1:0];
        o_c_out  = w_sum[N];
        o_ovf    = w_arith_ovf;
`ifdef ALU_PIPE_SAT_EN
        // both operands share a sign on overflow, so A's sign picks the rail
        if (w_arith_ovf)
          o_result = i_a[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
`endif
      end
      OP_OR:  o_result = i_a | i_b;
      OP_AND: o_result = i_a & i_b;
      OP_XOR: o_result = i_a ^ i_b;
      OP_SLT: o_result = {{(N-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
      default: o_result = '0;
    endcase
  end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU pipeline with registered flags and consumed-result counter.
// Build option ALU_PIPE_SAT_EN enables saturating ADD/SUB inside alu_core.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int N  = 32,
  parameter int CW = 16
) (
  input logic       clk,
  input logic       rst_n,
  alu_pipe_if.slave bus
);

  logic          r_s1_valid;
  logic [2:0]    r_s1_op;
  logic          r_s1_cin;
  logic [N-1:0]  r_s1_a;
  logic [N-1:0]  r_s1_b;
  logic          r_s2_valid;
  logic [N-1:0]  r_r1;
  logic [3:0]    r_flags;
  logic [CW-1:0] r_count;

  logic          w_s2_adv;
  logic          w_s1_adv;
  logic          w_accept;
  logic          w_s2_load;
  logic [N-1:0]  w_result;
  logic          w_c;
  logic          w_v;

  assign w_s2_adv  = !r_s2_valid || bus.out_ready;
  assign w_s1_adv  = !r_s1_valid || w_s2_adv;
  assign w_accept  = bus.in_valid && w_s1_adv;
  assign w_s2_load = r_s1_valid && w_s2_adv;

  // operand registers load only on acceptance so idle-bus garbage never enters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_op    <= OP_MOV;
      r_s1_cin   <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
    end else begin
      if (w_s1_adv) r_s1_valid <= bus.in_valid;
      if (w_accept) begin
        r_s1_op  <= bus.ALUOp;
        r_s1_cin <= bus.c_in;
        r_s1_a   <= bus.R2;
        r_s1_b   <= bus.R3;
      end
    end
  end

  alu_core #(.N(N)) u_core (
    .i_op     (r_s1_op),
    .i_a      (r_s1_a),
    .i_b      (r_s1_b),
    .i_cin    (r_s1_cin),
    .o_result (w_result),
    .o_c_out  (w_c),
    .o_ovf    (w_v)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_r1       <= '0;
      r_flags    <= '0;
    end else begin
      if (w_s2_adv) r_s2_valid <= r_s1_valid;
      if (w_s2_load) begin
        r_r1           <= w_result;
        r_flags[FLG_C] <= w_c;
        r_flags[FLG_V] <= w_v;
        r_flags[FLG_Z] <= (w_result == '0);
        r_flags[FLG_N] <= w_result[N-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         r_count <= '0;
    else if (r_s2_valid && bus.out_ready) r_count <= r_count + CW'(1);
  end

  assign bus.in_ready  = w_s1_adv;
  assign bus.out_valid = r_s2_valid;
  assign bus.R1        = r_r1;
  assign bus.c_out     = r_flags[FLG_C];
  assign bus.ovf       = r_flags[FLG_V];
  assign bus.zero      = r_flags[FLG_Z];
  assign bus.neg       = r_flags[FLG_N];
  assign bus.op_count  = r_count;

endmodule
